e203_exu_fpu_fmis_wbck_buf: RTL and testbench
=============================================

// Module: e203_exu_fpu_fmis_wbck_buf
// PURPOSE
//  Result buffer directly downstream of the FPU misc units (fclass, and later
//  fsgnj/fmin/fmax). Captures the 32-bit writeback data and destination index
//  into a small FIFO, then presents them to the FPU writeback arbiter.
//  i_ready depends only on buffer state, never on o_ready, so the arbiter's
//  ready path does not reach the misc units.
// PARAMETERS
//  DEPTH   2    entry count; power of 2, >= 2
//  AW      1    pointer width; must equal log2(DEPTH)
// PORTS
//  clk         in   1     core clock
//  rst         in   1     async reset, active-high
//  i_valid     in   1     upstream result valid
//  i_ready     out  1     buffer can accept an entry
//  i_wdat      in   32    result word (class mask in [9:0] for fclass)
//  i_rdidx     in   5     destination f-register index
//  i_flush     in   1     pipeline flush; discards every held entry
//  o_valid     out  1     entry available to the writeback arbiter
//  o_ready     in   1     arbiter accepts the entry
//  o_wdat      out  32    head entry data
//  o_rdidx     out  5     head entry index
//  o_cnt       out  AW+1  current occupancy (0..DEPTH)
// BEHAVIOUR
//  - One clock, clk. Reset rst is asynchronous and active-high.
//  - Reset: wptr=0, rptr=0, cnt=0, so o_valid=0, o_cnt=0 and i_ready=1.
//    o_wdat and o_rdidx are 0 while empty (the output mux is gated by o_valid).
//  - Push = i_valid & i_ready & ~i_flush.
//  - Pop  = o_valid & o_ready, taken from the registered head entry.
//  - i_ready = (cnt != DEPTH). It is combinational from state only.
//  - o_valid = (cnt != 0), with the bypass term added when the macro is set.
//  - Storage: DEPTH x 37 register array, written at wptr on push.
//    wptr and rptr are AW bits and wrap modulo DEPTH without a special case.
//  - cnt update: cnt + push - pop. Simultaneous push and pop leaves cnt unchanged.
//  - Full: i_ready=0, the upstream holds, and nothing is overwritten.
//    A pop in the full cycle raises i_ready in the next cycle.
//  - Empty: o_valid=0. A pop request is ignored and cnt never underflows.
//  - Order: strict FIFO. Latency is 1 cycle from the push edge to o_valid.
//  - i_flush (synchronous) sets wptr=rptr=cnt=0 at the next edge.
//    A push in the same cycle is dropped.
//    A pop in the same cycle still completes, because the arbiter has already
//    sampled it.
//  - rst asserted mid-operation: all entries are lost immediately and the
//    outputs go to their reset values asynchronously.
//  - No arithmetic on data. Data passes through bit-exact.
// CONFIGURATION
//  E203_FPU_FMIS_WBCK_BYPASS_EN
//   Defined: when cnt==0 and i_valid & ~i_flush, the input drives the outputs
//    in the same cycle (o_valid=1, o_wdat=i_wdat, o_rdidx=i_rdidx).
//    If o_ready=1, the entry is consumed and is not written (0 latency).
//    If o_ready=0, it is written as a normal push.
//    i_ready is still state-only.
//   Undefined: there is no bypass, and every result takes exactly 1 cycle.
// TESTING
//  1 Reset: assert rst for 3 cycles -> o_valid=0, i_ready=1, o_cnt=0.
//    Deassert with no traffic -> values hold.
//  2 Latency: push wdat=32'h0000_0200, rdidx=5'd3 with o_ready=1 ->
//    o_valid=1 next cycle with 32'h200/3. Bypass build: same cycle.
//  3 Full/backpressure: o_ready=0, push 0x1,0x2 -> o_cnt=2, i_ready=0.
//    Hold i_valid with 0x3 -> not accepted. Release o_ready ->
//    outputs 0x1,0x2,0x3 in order.
//  4 Wrap: stream 10 entries 0xA0..0xA9 with o_ready toggling every cycle ->
//    all 10 arrive in order with no loss or duplicate. o_cnt never exceeds 2.
//  5 Flush: with cnt=2, assert i_flush together with i_valid (0x55) ->
//    next cycle o_cnt=0, o_valid=0, and 0x55 never appears at the output.
//  6 Mid-op reset: with cnt=1, pulse rst asynchronously between edges ->
//    o_valid drops to 0 before the next edge. The first push after release
//    is output first.

Source files
------------

// File: rtl/e203_exu_fpu_fmis_wbck_buf.sv
// FIFO result buffer between the FPU misc units and the FPU writeback arbiter.
// Define E203_FPU_FMIS_WBCK_BYPASS_EN to let an empty buffer pass input straight to the output.
module e203_exu_fpu_fmis_wbck_buf #(
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   output logic          i_ready,
   input  logic [31:0]   i_wdat,
   input  logic [4:0]    i_rdidx,
   input  logic          i_flush,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [31:0]   o_wdat,
   output logic [4:0]    o_rdidx,
   output logic [AW:0]   o_cnt
);

   typedef struct packed {
      logic [4:0]  rdidx;
      logic [31:0] wdat;
   } ent_t;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   ent_t          mem [DEPTH];
   ent_t          head;
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   cnt;
   logic          st_vld, push_req, push, pop;

   assign st_vld   = (cnt != '0);
   // Ready looks only at occupancy so o_ready never reaches upstream.
   assign i_ready  = (cnt != FULL);
   assign push_req = i_valid & i_ready & ~i_flush;
   assign pop      = st_vld & o_ready;

`ifdef E203_FPU_FMIS_WBCK_BYPASS_EN
   logic byp;
   assign byp     = ~st_vld & i_valid & ~i_flush;
   // A bypassed entry taken by the arbiter this cycle must not also be stored.
   assign push    = push_req & ~(byp & o_ready);
   assign o_valid = st_vld | byp;
   assign head    = byp ? ent_t'{rdidx: i_rdidx, wdat: i_wdat} : mem[rptr];
`else
   assign push    = push_req;
   assign o_valid = st_vld;
   assign head    = mem[rptr];
`endif

   assign o_wdat  = o_valid ? head.wdat  : '0;
   assign o_rdidx = o_valid ? head.rdidx : '0;
   assign o_cnt   = cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (i_flush) begin
         // Any pop this cycle is already complete at the arbiter; just clear.
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= ent_t'{rdidx: i_rdidx, wdat: i_wdat};
   end

endmodule

// File: tb/tb_e203_exu_fpu_fmis_wbck_buf.sv
// Directed bench for e203_exu_fpu_fmis_wbck_buf: reset, latency, backpressure, wrap, flush, async reset.
module tb_e203_exu_fpu_fmis_wbck_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid, i_ready, i_flush, o_valid, o_ready;
   logic [31:0] i_wdat, o_wdat;
   logic [4:0]  i_rdidx, o_rdidx;
   logic [1:0]  o_cnt;

   int total = 0;
   int bad   = 0;

   e203_exu_fpu_fmis_wbck_buf #(.DEPTH(2), .AW(1)) dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_ready(i_ready), .i_wdat(i_wdat), .i_rdidx(i_rdidx),
      .i_flush(i_flush),
      .o_valid(o_valid), .o_ready(o_ready), .o_wdat(o_wdat), .o_rdidx(o_rdidx),
      .o_cnt(o_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int tx, rx, cyc;
      rst = 1'b1; i_valid = 1'b0; i_wdat = '0; i_rdidx = '0; i_flush = 1'b0; o_ready = 1'b0;

      // 1 reset
      repeat (3) step();
      chk("rst_ovalid", o_valid, 0);
      chk("rst_iready", i_ready, 1);
      chk("rst_cnt",    o_cnt,   0);
      chk("rst_wdat",   o_wdat,  0);
      rst = 1'b0;
      repeat (2) step();
      chk("idle_ovalid", o_valid, 0);
      chk("idle_iready", i_ready, 1);
      chk("idle_cnt",    o_cnt,   0);

      // 2 latency
      i_valid = 1'b1; i_wdat = 32'h0000_0200; i_rdidx = 5'd3; o_ready = 1'b1;
      #1;
`ifdef E203_FPU_FMIS_WBCK_BYPASS_EN
      chk("lat_byp_valid", o_valid, 1);
      chk("lat_byp_wdat",  o_wdat,  32'h200);
      step();
      i_valid = 1'b0;
      chk("lat_byp_cnt", o_cnt, 0);
`else
      chk("lat_pre_valid", o_valid, 0);
      step();
      i_valid = 1'b0;
      #1;
      chk("lat_valid", o_valid, 1);
      chk("lat_wdat",  o_wdat,  32'h200);
      chk("lat_rdidx", o_rdidx, 3);
      chk("lat_cnt",   o_cnt,   1);
      step();
      chk("lat_drain", o_valid, 0);
`endif

      // 3 full / backpressure
      o_ready = 1'b0;
      i_valid = 1'b1; i_wdat = 32'h1; i_rdidx = 5'd1;
      step();
      i_wdat = 32'h2; i_rdidx = 5'd2;
      step();
      chk("full_cnt",    o_cnt,   2);
      chk("full_iready", i_ready, 0);
      chk("full_head",   o_wdat,  1);
      i_wdat = 32'h3; i_rdidx = 5'd3;
      repeat (2) step();
      chk("hold_cnt",  o_cnt,  2);
      chk("hold_head", o_wdat, 1);
      o_ready = 1'b1;
      step();
      chk("bp_out2",    o_wdat,  2);
      chk("bp_cnt1",    o_cnt,   1);
      chk("bp_iready",  i_ready, 1);
      step();
      i_valid = 1'b0;
      chk("bp_out3",   o_wdat,  3);
      chk("bp_rdidx3", o_rdidx, 3);
      chk("bp_cnt_a",  o_cnt,   1);
      step();
      chk("bp_empty", o_cnt, 0);

      // 4 wrap stream with toggling o_ready
      tx = 0; rx = 0; cyc = 0;
      o_ready = 1'b0;
      while (rx < 10 && cyc < 100) begin
         i_valid = (tx < 10);
         i_wdat  = 32'hA0 + tx;
         i_rdidx = 5'(tx);
         o_ready = ~o_ready;
         @(negedge clk);
         if (o_valid && o_ready) begin
            chk("wrap_data", o_wdat, 32'hA0 + rx);
            rx++;
         end
         if (i_valid && i_ready) tx++;
         chk("wrap_cnt_le2", o_cnt <= 2, 1);
         step();
         cyc++;
      end
      i_valid = 1'b0;
      chk("wrap_rx", rx, 10);
      chk("wrap_tx", tx, 10);
      chk("wrap_end_cnt", o_cnt, 0);

      // 5 flush with simultaneous push
      o_ready = 1'b0;
      i_valid = 1'b1; i_wdat = 32'h11;
      step();
      i_wdat = 32'h22;
      step();
      chk("fl_pre_cnt", o_cnt, 2);
      i_flush = 1'b1; i_wdat = 32'h55;
      step();
      i_flush = 1'b0; i_valid = 1'b0;
      chk("fl_cnt",    o_cnt,   0);
      chk("fl_valid",  o_valid, 0);
      chk("fl_wdat",   o_wdat,  0);
      o_ready = 1'b1;
      repeat (3) step();
      chk("fl_no55", o_valid, 0);

      // 6 async reset mid-operation
      o_ready = 1'b0;
      i_valid = 1'b1; i_wdat = 32'h77; i_rdidx = 5'd7;
      step();
      i_valid = 1'b0;
      chk("ar_pre_cnt", o_cnt, 1);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", o_valid, 0);
      chk("ar_cnt",   o_cnt,   0);
      chk("ar_wdat",  o_wdat,  0);
      step();
      rst = 1'b0;
      i_valid = 1'b1; i_wdat = 32'hDEAD_BEEF; i_rdidx = 5'd9;
      step();
      i_valid = 1'b0;
      chk("ar_first_wdat",  o_wdat,  32'hDEAD_BEEF);
      chk("ar_first_rdidx", o_rdidx, 9);
      chk("ar_first_cnt",   o_cnt,   1);
      o_ready = 1'b1;
      step();
      chk("ar_final_cnt", o_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
